// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// ahb_sram_slave : AHB-Lite subordinate over a flop-based 32-bit word memory.
// Optional macro AHB_SRAM_ERR_EN enables ERROR responses; Revision 1.0
// ============================================================================
module ahb_sram_slave #(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);
   localparam int         AW      = $clog2(DEPTH);
   localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    lo_q, lo_d;
   logic [2:0]    size_q, size_d;
   logic          write_q, write_d;
   logic          good_q, good_d;
   logic [31:0]   mem_q [DEPTH];

   logic       in_range, aligned, good_req, ready_state, accept, wr_en;
   logic [3:0] strb;
   logic       unused;

   assign unused = &{1'b0, hburst, htrans[0]};

   // BASE_ADDR is aligned to the memory size, so range reduces to a tag match.
   always_comb begin
      in_range = (haddr[31:AW+2] == BASE_ADDR[31:AW+2]);
      case (hsize)
         3'b000:  aligned = 1'b1;
         3'b001:  aligned = ~haddr[0];
         default: aligned = (haddr[1:0] == 2'b00);
      endcase
      good_req    = in_range & aligned;
      ready_state = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
      accept      = hsel & htrans[1] & hready & ready_state;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      size_d  = size_q;
      write_d = write_q;
      good_d  = good_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_DATA;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               idx_d   = haddr[AW+1:2];
               lo_d    = haddr[1:0];
               size_d  = hsize;
               write_d = hwrite;
               good_d  = good_req;
               if (WAIT_STATES == 0) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_INIT;
               end
`ifdef AHB_SRAM_ERR_EN
               if (!good_req) state_d = ST_ERR1;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         lo_q    <= 2'd0;
         size_q  <= 3'd0;
         write_q <= 1'b0;
         good_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         size_q  <= size_d;
         write_q <= write_d;
         good_q  <= good_d;
      end
   end

   always_comb begin
      case (size_q)
         3'b000:  strb = 4'b0001 << lo_q;
         3'b001:  strb = lo_q[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
   end

   // Bad transfers never touch the array, with or without the error path.
   assign wr_en = (state_q == ST_DATA) && write_q && good_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

   assign hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
`ifdef AHB_SRAM_ERR_EN
   assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
   assign hresp     = 1'b0;
`endif
   assign hrdata    = ((state_q == ST_DATA) && !write_q && good_q) ? mem_q[idx_q] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// tb_ahb_sram_slave : pipelined random AHB-Lite traffic on a zero-wait and a
// three-wait instance, checked against a byte-level memory model.
module tb_ahb_sram_slave;
   localparam int DEPTH  = 64;
   localparam int BUDGET = 6000;
`ifdef AHB_SRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      bit          idle;
      bit          sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      bit          wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          lit;
      logic [31:0] lit_val;
   } txn_t;

   logic        clk = 1'b0;
   logic        nrst;
   logic        hsel [2];
   logic [31:0] haddr [2];
   logic [1:0]  htrans [2];
   logic        hwrite [2];
   logic [2:0]  hsize [2];
   logic [2:0]  hburst [2];
   logic [31:0] hwdata [2];
   logic        hready [2];
   logic        hreadyout [2];
   logic        hresp [2];
   logic [31:0] hrdata [2];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mdl [2][DEPTH];
   txn_t        q[$];

   always #5 clk = ~clk;

   assign hready[0] = hreadyout[0];
   assign hready[1] = hreadyout[1];

   ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .nrst(nrst), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
      .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
      .hready(hready[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

   ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3)) u_dut1 (
      .clk(clk), .nrst(nrst), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
      .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
      .hready(hready[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? 32'h0000_0000 : 32'h0000_2000;
   endfunction

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
      txn_t t;
      t.idle = 1'b0; t.sel = 1'b1; t.trans = {1'b1, 1'($urandom)};
      t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata;
      t.lit = 1'b0; t.lit_val = 32'h0;
      return t;
   endfunction

   function automatic txn_t mk_idle();
      txn_t t;
      t = mk(1'($urandom), $urandom, 3'($urandom), $urandom);
      t.idle  = 1'b1;
      t.sel   = 1'($urandom);
      t.trans = t.sel ? {1'b0, 1'($urandom)} : 2'($urandom);
      return t;
   endfunction

   function automatic bit good(input int d, input txn_t t);
      logic [31:0] off;
      bit al;
      off = t.addr - base_of(d);
      if (t.size == 3'd0)      al = 1'b1;
      else if (t.size == 3'd1) al = (t.addr % 2) == 0;
      else                     al = (t.addr % 4) == 0;
      return (off < DEPTH * 4) && al;
   endfunction

   function automatic int idx_of(input int d, input txn_t t);
      return int'(((t.addr - base_of(d)) >> 2) % DEPTH);
   endfunction

   function automatic bit exp_err(input int d, input txn_t t);
      return ERR_EN && !good(d, t);
   endfunction

   function automatic int exp_waits(input int d, input txn_t t);
      return exp_err(d, t) ? 1 : ws_of(d);
   endfunction

   function automatic logic [31:0] exp_rdata(input int d, input txn_t t);
      return (!t.wr && good(d, t)) ? mdl[d][idx_of(d, t)] : 32'h0;
   endfunction

   // Each byte of the transfer lands at its own byte address within the word.
   task automatic model_write(input int d, input txn_t t);
      int n, idx, off;
      logic [31:0] w;
      if (!good(d, t)) return;
      n   = (t.size == 3'd0) ? 1 : (t.size == 3'd1) ? 2 : 4;
      idx = idx_of(d, t);
      w   = mdl[d][idx];
      for (int k = 0; k < n; k++) begin
         off = int'((t.addr + 32'(k)) % 4);
         w[8*off +: 8] = t.wdata[8*off +: 8];
      end
      mdl[d][idx] = w;
   endtask

   task automatic drive_addr(input int d, input txn_t t);
      hsel[d]   = t.sel;
      htrans[d] = t.trans;
      haddr[d]  = t.addr;
      hwrite[d] = t.wr;
      hsize[d]  = t.size;
      hburst[d] = 3'($urandom);
   endtask

   function automatic txn_t pop();
      if (q.size() > 0) return q.pop_front();
      return mk_idle();
   endfunction

   task automatic run_seq(input int d);
      txn_t a, dp;
      bit   dv, rdy;
      int   waits, cyc;
      dv = 1'b0; waits = 0; cyc = 0;
      dp = mk_idle();
      a  = pop();
      drive_addr(d, a);
      while (q.size() > 0 || !a.idle || dv) begin
         @(negedge clk);
         rdy = hreadyout[d];
         cyc++;
         if (cyc > BUDGET) begin
            check($sformatf("seq_budget[%0d]", d), cyc, BUDGET);
            q.delete();
            return;
         end
         if (dv) begin
            check($sformatf("hresp[%0d]", d), 32'(hresp[d]), 32'(exp_err(d, dp)));
            if (!rdy) begin
               check($sformatf("hrdata_wait[%0d]", d), hrdata[d], 32'h0);
               waits++;
               if (waits > exp_waits(d, dp)) begin
                  check($sformatf("waits[%0d]", d), waits, exp_waits(d, dp));
                  q.delete();
                  return;
               end
            end else begin
               check($sformatf("waits[%0d]", d), waits, exp_waits(d, dp));
               check($sformatf("hrdata[%0d]", d), hrdata[d], exp_rdata(d, dp));
               if (dp.lit) check($sformatf("hrdata_lit[%0d]", d), hrdata[d], dp.lit_val);
            end
         end else begin
            check($sformatf("idle_ready[%0d]", d), 32'(rdy), 32'd1);
            check($sformatf("idle_resp[%0d]", d), 32'(hresp[d]), 32'd0);
            check($sformatf("idle_rdata[%0d]", d), hrdata[d], 32'h0);
         end
         @(posedge clk);
         #1;
         if (rdy) begin
            if (dv && dp.wr) model_write(d, dp);
            dp        = a;
            dv        = !a.idle;
            waits     = 0;
            hwdata[d] = (dv && dp.wr) ? dp.wdata : $urandom;
            a         = pop();
            drive_addr(d, a);
         end
      end
   endtask

   task automatic gen_random(input int d, input int n);
      int r, idx;
      logic [2:0]  size;
      logic [31:0] addr;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 99);
         if (r < 20) begin
            q.push_back(mk_idle());
         end else begin
            size = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) size = 3'($urandom_range(3, 7));
            idx  = $urandom_range(0, DEPTH - 1);
            addr = base_of(d) + 32'(idx * 4);
            if (size == 3'd0)      addr += 32'($urandom_range(0, 3));
            else if (size == 3'd1) addr += 32'(2 * $urandom_range(0, 1));
            if (r >= 90) begin
               if (ERR_EN && r >= 95 && size != 3'd0) addr += 32'd1;
               else addr = base_of(d) + 32'(DEPTH * 4) + 32'(idx * 4);
            end
            q.push_back(mk(1'($urandom), addr, size, $urandom));
         end
      end
   endtask

   function automatic txn_t rd_lit(input logic [31:0] addr, input logic [31:0] v);
      txn_t t;
      t = mk(1'b0, addr, 3'd2, $urandom);
      t.lit = 1'b1;
      t.lit_val = v;
      return t;
   endfunction

   initial begin
      txn_t t;
      nrst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         t = mk_idle();
         t.sel = 1'b0;
         drive_addr(d, t);
         hwdata[d] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_ready[%0d]", d), 32'(hreadyout[d]), 32'd1);
         check($sformatf("rst_resp[%0d]", d), 32'(hresp[d]), 32'd0);
         check($sformatf("rst_rdata[%0d]", d), hrdata[d], 32'h0);
      end
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < DEPTH; i++)
            q.push_back(mk(1'b1, base_of(d) + 32'(i * 4), 3'd2, $urandom));
         run_seq(d);
      end

      // Zero-wait instance: back-to-back write/read and sub-word lanes.
      q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF));
      q.push_back(rd_lit(32'h10, 32'hDEAD_BEEF));
      q.push_back(mk(1'b1, 32'h10, 3'd2, 32'h1122_3344));
      q.push_back(mk(1'b1, 32'h13, 3'd0, 32'hAA5A_C3E1));
      q.push_back(rd_lit(32'h10, 32'hAA22_3344));
      q.push_back(mk(1'b1, 32'h12, 3'd1, 32'h5566_0000));
      q.push_back(rd_lit(32'h10, 32'h5566_3344));
      q.push_back(rd_lit(32'h0000_0100, 32'h0));
      q.push_back(mk(1'b1, 32'h0000_0100, 3'd2, 32'hFFFF_FFFF));
      q.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
      if (ERR_EN) begin
         q.push_back(mk(1'b1, 32'h02, 3'd2, 32'hCAFE_F00D));
         q.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
      end
      run_seq(0);
      gen_random(0, 400);
      run_seq(0);

      // Three-wait instance: pipelined reads held through wait states.
      q.push_back(mk(1'b0, 32'h2010, 3'd2, 32'h0));
      q.push_back(mk(1'b0, 32'h2014, 3'd2, 32'h0));
      q.push_back(mk(1'b1, 32'h2014, 3'd2, 32'h0BAD_CAFE));
      q.push_back(rd_lit(32'h2014, 32'h0BAD_CAFE));
      q.push_back(rd_lit(32'h2100, 32'h0));
      run_seq(1);
      gen_random(1, 300);
      run_seq(1);

      // Reset in the middle of a write's wait states.
      t = mk(1'b1, 32'h2010, 3'd2, 32'h1234_5678);
      drive_addr(1, t);
      @(posedge clk);
      #1;
      t = mk_idle();
      t.sel = 1'b0;
      drive_addr(1, t);
      hwdata[1] = 32'h1234_5678;
      @(negedge clk);
      check("pre_rst_wait", 32'(hreadyout[1]), 32'd0);
      #2 nrst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(hreadyout[1]), 32'd1);
      check("mid_rst_resp", 32'(hresp[1]), 32'd0);
      check("mid_rst_rdata", hrdata[1], 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      q.push_back(mk(1'b0, 32'h2010, 3'd2, 32'h0));
      q.push_back(mk(1'b1, 32'h2018, 3'd2, 32'h7777_0001));
      q.push_back(rd_lit(32'h2018, 32'h7777_0001));
      run_seq(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
